mmu_seq_ctrl: RTL and testbench

//  Job sequencer for the 2x2 systolic matrix multiplier unit (mmu).
//  - Holds one A and one B 2x2 operand tile loaded by the host.
//  - On start: clears the MMU accumulators, then drives the skewed A/B feed with valid_in.
//  - Counts mmu valid_out beats, latches the 2x2 C result and raises done.
//  - Sits between the host/load path and one mmu instance.

---
 rtl/mmu_pkg.sv | 23 ++
 rtl/mmu_skew_feed.sv | 27 ++
 rtl/mmu_seq_ctrl.sv | 177 +++++++++++++++++
 tb/tb_mmu_seq_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmu_pkg.sv
`default_nettype none
// ============================================================================
// mmu_pkg : shared constants and types for the MMU job sequencer
// Rev 1.0
// ============================================================================
package mmu_pkg;

  localparam int MMU_DATA_W = 8;
  localparam int MMU_ACC_W  = 16;
  localparam int FEED_LEN   = 3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    FEED  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_e;

  typedef logic [1:0][1:0][MMU_DATA_W-1:0] tile_t;

endpackage
`default_nettype wire

// File: rtl/mmu_skew_feed.sv
`default_nettype none
// ============================================================================
// mmu_skew_feed : maps operand tiles and feed step t to skewed a_in/b_in lanes
// Rev 1.0
// ============================================================================
module mmu_skew_feed
  import mmu_pkg::*;
#(
  parameter int DATA_W = MMU_DATA_W
) (
  input  logic [1:0][1:0][DATA_W-1:0] a_tile,
  input  logic [1:0][1:0][DATA_W-1:0] b_tile,
  input  logic [1:0]                  t,
  output logic [1:0][DATA_W-1:0]      a_in,
  output logic [1:0][DATA_W-1:0]      b_in
);

  // Lane i reads index k = t - i; k >= 2 (including the wrap of t < i) is zero.
  for (genvar i = 0; i < 2; i++) begin : g_lane
    logic [1:0] k;
    assign k       = t - 2'(i);
    assign a_in[i] = k[1] ? '0 : a_tile[i][k[0]];
    assign b_in[i] = k[1] ? '0 : b_tile[k[0]][i];
  end

endmodule
`default_nettype wire

// File: rtl/mmu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// mmu_seq_ctrl : job sequencer for the 2x2 systolic MMU (load, clear, feed, capture)
// Optional DRAIN watchdog enabled by defining MMU_SEQ_TIMEOUT_EN.
// Rev 1.0
// ============================================================================
module mmu_seq_ctrl
  import mmu_pkg::*;
#(
  parameter int DATA_W  = MMU_DATA_W,
  parameter int ACC_W   = MMU_ACC_W,
  parameter int TIMEOUT = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ld_en,
  input  logic                ld_sel,
  input  logic                ld_row,
  input  logic                ld_col,
  input  logic [DATA_W-1:0]   ld_data,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [4*ACC_W-1:0]  res_c,
  output logic                mmu_rst,
  output logic [2*DATA_W-1:0] mmu_a,
  output logic [2*DATA_W-1:0] mmu_b,
  output logic                mmu_valid_in,
  input  logic                mmu_valid_out,
  input  logic [4*ACC_W-1:0]  mmu_c
);

  if (TIMEOUT < 1) begin : g_timeout_check
    $error("mmu_seq_ctrl: TIMEOUT must be at least 1");
  end

  state_e                      state_q, state_d;
  logic [1:0][1:0][DATA_W-1:0] a_tile_q, a_tile_d;
  logic [1:0][1:0][DATA_W-1:0] b_tile_q, b_tile_d;
  logic [1:0]                  t_q, t_d;
  logic [1:0]                  beat_q, beat_d;
  logic [4*ACC_W-1:0]          res_c_q, res_c_d;
  logic                        mmu_rst_q, mmu_rst_d;
  logic                        mmu_valid_in_q, mmu_valid_in_d;
  logic [2*DATA_W-1:0]         mmu_a_q, mmu_a_d;
  logic [2*DATA_W-1:0]         mmu_b_q, mmu_b_d;
  logic [1:0][DATA_W-1:0]      skew_a, skew_b;
  logic                        third_beat;
  logic                        timeout_hit;

  // Skew is looked up for the next cycle's step so the feed leaves a flop.
  mmu_skew_feed #(.DATA_W(DATA_W)) u_skew (
    .a_tile (a_tile_q),
    .b_tile (b_tile_q),
    .t      (t_d),
    .a_in   (skew_a),
    .b_in   (skew_b)
  );

  always_comb begin
    state_d    = state_q;
    a_tile_d   = a_tile_q;
    b_tile_d   = b_tile_q;
    t_d        = '0;
    beat_d     = beat_q;
    res_c_d    = res_c_q;
    third_beat = mmu_valid_out && (beat_q == 2'd2);

    if ((state_q == FEED || state_q == DRAIN) && mmu_valid_out && beat_q != 2'd3)
      beat_d = beat_q + 2'd1;

    case (state_q)
      IDLE: begin
        if (start)
          state_d = CLEAR;
        else if (ld_en) begin
          if (ld_sel) b_tile_d[ld_row][ld_col] = ld_data;
          else        a_tile_d[ld_row][ld_col] = ld_data;
        end
      end
      CLEAR: begin
        beat_d  = '0;
        state_d = FEED;
      end
      FEED: begin
        t_d = t_q + 2'd1;
        if (third_beat) begin
          res_c_d = mmu_c;
          state_d = DONE;
        end else if (t_q == 2'(FEED_LEN - 1))
          state_d = DRAIN;
      end
      DRAIN: begin
        if (third_beat) begin
          res_c_d = mmu_c;
          state_d = DONE;
        end else if (timeout_hit)
          state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    mmu_rst_d      = (state_d == CLEAR);
    mmu_valid_in_d = (state_d == FEED);
    mmu_a_d        = mmu_valid_in_d ? skew_a : '0;
    mmu_b_d        = mmu_valid_in_d ? skew_b : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      a_tile_q       <= '0;
      b_tile_q       <= '0;
      t_q            <= '0;
      beat_q         <= '0;
      res_c_q        <= '0;
      mmu_rst_q      <= 1'b0;
      mmu_valid_in_q <= 1'b0;
      mmu_a_q        <= '0;
      mmu_b_q        <= '0;
    end else begin
      state_q        <= state_d;
      a_tile_q       <= a_tile_d;
      b_tile_q       <= b_tile_d;
      t_q            <= t_d;
      beat_q         <= beat_d;
      res_c_q        <= res_c_d;
      mmu_rst_q      <= mmu_rst_d;
      mmu_valid_in_q <= mmu_valid_in_d;
      mmu_a_q        <= mmu_a_d;
      mmu_b_q        <= mmu_b_d;
    end
  end

`ifdef MMU_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);

  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_q, err_d;

  always_comb begin
    wd_d = '0;
    if (state_q == DRAIN) wd_d = wd_q + WD_W'(1);
  end

  // A real third beat on the last watchdog cycle wins over the timeout.
  assign timeout_hit = (wd_q == WD_W'(TIMEOUT - 1));
  assign err_d       = (state_q == DRAIN) && timeout_hit && !third_beat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);
  assign res_c        = res_c_q;
  assign mmu_rst      = mmu_rst_q;
  assign mmu_a        = mmu_a_q;
  assign mmu_b        = mmu_b_q;
  assign mmu_valid_in = mmu_valid_in_q;

endmodule
`default_nettype wire

// File: tb/tb_mmu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// tb_mmu_seq_ctrl : randomized self-checking bench with a timeline reference model
// Rev 1.0
// ============================================================================
module tb_mmu_seq_ctrl;

  localparam int DW = 8;
  localparam int AW = 16;
  localparam int TO = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            ld_en, ld_sel, ld_row, ld_col, start;
  logic [DW-1:0]   ld_data;
  logic            busy, done, err, mmu_rst, mmu_valid_in, mmu_valid_out;
  logic [4*AW-1:0] res_c, mmu_c;
  logic [2*DW-1:0] mmu_a, mmu_b;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0]   ma [2][2];
  logic [DW-1:0]   mb [2][2];
  logic [4*AW-1:0] c_exp;
  logic [4*AW-1:0] prev_res;
  int              lat;
  bit              vo_kill;
  logic [7:0]      vhist;
  int              nb;

  always #5 clk = ~clk;

  mmu_seq_ctrl #(.DATA_W(DW), .ACC_W(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .ld_en(ld_en), .ld_sel(ld_sel), .ld_row(ld_row),
    .ld_col(ld_col), .ld_data(ld_data), .start(start), .busy(busy), .done(done),
    .err(err), .res_c(res_c), .mmu_rst(mmu_rst), .mmu_a(mmu_a), .mmu_b(mmu_b),
    .mmu_valid_in(mmu_valid_in), .mmu_valid_out(mmu_valid_out), .mmu_c(mmu_c)
  );

  // MMU stand-in: valid_out echoes valid_in after lat cycles; C is presented on the 3rd beat.
  always @(posedge clk or posedge rst) begin
    if (rst || mmu_rst) begin
      vhist <= '0;
      nb    <= 0;
    end else begin
      vhist <= {vhist[6:0], mmu_valid_in};
      if (mmu_valid_out) nb <= nb + 1;
    end
  end

  always_comb begin
    mmu_valid_out = 1'b0;
    if (!vo_kill) begin
      if (lat == 0) mmu_valid_out = mmu_valid_in;
      else          mmu_valid_out = vhist[(lat - 1) & 7];
    end
    mmu_c = (mmu_valid_out && nb == 2) ? c_exp : ~c_exp;
  end

  function automatic logic [4*AW-1:0] prod();
    logic [4*AW-1:0] r;
    r = '0;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++)
        r[(2*i+j)*AW +: AW] = AW'(int'(ma[i][0]) * int'(mb[0][j]) + int'(ma[i][1]) * int'(mb[1][j]));
    return r;
  endfunction

  function automatic logic [2*DW-1:0] exp_a(input int t);
    logic [2*DW-1:0] r;
    r = '0;
    for (int i = 0; i < 2; i++)
      if (t - i >= 0 && t - i <= 1) r[i*DW +: DW] = ma[i][t-i];
    return r;
  endfunction

  function automatic logic [2*DW-1:0] exp_b(input int t);
    logic [2*DW-1:0] r;
    r = '0;
    for (int j = 0; j < 2; j++)
      if (t - j >= 0 && t - j <= 1) r[j*DW +: DW] = mb[t-j][j];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        ma[i][j] = '0;
        mb[i][j] = '0;
      end
    c_exp    = prod();
    prev_res = '0;
  endtask

  task automatic load(input bit sel, input int r, input int c, input logic [DW-1:0] d);
    ld_en = 1'b1; ld_sel = sel; ld_row = r[0]; ld_col = c[0]; ld_data = d;
    tick();
    ld_en = 1'b0;
    if (sel) mb[r][c] = d;
    else     ma[r][c] = d;
    c_exp = prod();
  endtask

  task automatic load_random();
    for (int k = 0; k < 8; k++) load(k[2], k / 2 % 2, k % 2, DW'($urandom));
    repeat (2) load(1'($urandom), $urandom_range(0, 1), $urandom_range(0, 1), DW'($urandom));
  endtask

  // Timeline of one job relative to the accepting edge: n=1 CLEAR, n=2..4 FEED t=0..2,
  // third beat at n=4+lat, done at n=5+lat (or DRAIN entry + TO when no beats arrive).
  task automatic run_job(input int l, input bit kill, input bit noise);
    int exp_n;
    logic fd;
    logic [2*DW-1:0] ea, eb;
    lat = l; vo_kill = kill;
    exp_n = kill ? 5 + TO : 5 + l;
    start = 1'b1;
    ld_en = noise; ld_sel = 1'($urandom); ld_row = 1'($urandom); ld_col = 1'($urandom);
    ld_data = DW'($urandom);
    tick();
    start = 1'b0; ld_en = 1'b0;
    for (int n = 1; n <= exp_n; n++) begin
      fd = (n >= 2 && n <= 4);
      ea = fd ? exp_a(n - 2) : '0;
      eb = fd ? exp_b(n - 2) : '0;
      checks += 8;
      if (busy !== 1'b1) begin errors++; $display("FAIL job_busy n=%0d: got %b want 1", n, busy); end
      if (mmu_rst !== (n == 1)) begin errors++; $display("FAIL job_mmu_rst n=%0d: got %b want %b", n, mmu_rst, n == 1); end
      if (mmu_valid_in !== fd) begin errors++; $display("FAIL job_valid_in n=%0d: got %b want %b", n, mmu_valid_in, fd); end
      if (mmu_a !== ea) begin errors++; $display("FAIL job_mmu_a n=%0d: got %h want %h", n, mmu_a, ea); end
      if (mmu_b !== eb) begin errors++; $display("FAIL job_mmu_b n=%0d: got %h want %h", n, mmu_b, eb); end
      if (done !== (n == exp_n)) begin errors++; $display("FAIL job_done n=%0d: got %b want %b", n, done, n == exp_n); end
      if (err !== (kill && n == exp_n)) begin errors++; $display("FAIL job_err n=%0d: got %b want %b", n, err, kill && n == exp_n); end
      if (n == exp_n) begin
        if (res_c !== (kill ? prev_res : c_exp)) begin
          errors++; $display("FAIL job_res_c n=%0d: got %h want %h", n, res_c, kill ? prev_res : c_exp);
        end
      end else if (res_c !== prev_res) begin
        errors++; $display("FAIL job_res_hold n=%0d: got %h want %h", n, res_c, prev_res);
      end
      start  = (n == exp_n) ? 1'b1 : (noise ? 1'($urandom) : 1'b0);
      ld_en  = noise ? 1'($urandom) : 1'b0;
      ld_sel = 1'($urandom); ld_row = 1'($urandom); ld_col = 1'($urandom); ld_data = DW'($urandom);
      tick();
    end
    start = 1'b0; ld_en = 1'b0;
    checks += 3;
    if (busy !== 1'b0) begin errors++; $display("FAIL job_busy_after: got %b want 0", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL job_done_after: got %b want 0", done); end
    if (mmu_valid_in !== 1'b0) begin errors++; $display("FAIL job_valid_after: got %b want 0", mmu_valid_in); end
    if (!kill) prev_res = c_exp;
    vo_kill = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks += 2;
    if ({busy, done, err, mmu_rst, mmu_valid_in} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b want 00000", {busy, done, err, mmu_rst, mmu_valid_in});
    end
    if ({mmu_a, mmu_b, res_c} !== '0) begin
      errors++; $display("FAIL reset_data: got %h want 0", {mmu_a, mmu_b, res_c});
    end
    rst = 1'b0;
    model_reset();
    tick();
    checks++;
    if ({busy, done, err} !== 3'b0) begin errors++; $display("FAIL reset_idle: got %b want 000", {busy, done, err}); end
  endtask

  task automatic test_feed();
    load(0, 0, 0, 8'd1); load(0, 0, 1, 8'd2); load(0, 1, 0, 8'd3); load(0, 1, 1, 8'd4);
    load(1, 0, 0, 8'd5); load(1, 0, 1, 8'd6); load(1, 1, 0, 8'd7); load(1, 1, 1, 8'd8);
    run_job(2, 0, 0);
    checks++;
    if (res_c !== {16'd50, 16'd43, 16'd22, 16'd19}) begin
      errors++; $display("FAIL feed_result: got %h want %h", res_c, {16'd50, 16'd43, 16'd22, 16'd19});
    end
  endtask

  task automatic test_lockout();
    run_job(1, 0, 1);
    run_job(3, 0, 0);
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++) run_job(k, 0, 0);
  endtask

  task automatic test_random();
    repeat (10) begin
      if ($urandom_range(0, 3) != 0) begin
        load_random();
        checks++;
        if (res_c !== prev_res) begin errors++; $display("FAIL load_keeps_res: got %h want %h", res_c, prev_res); end
      end
      run_job($urandom_range(0, 4), 0, 1'($urandom));
    end
  endtask

  task automatic test_abort();
    load_random();
    run_job(1, 0, 0);
    load_random();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, err, mmu_rst, mmu_valid_in, mmu_a, mmu_b, res_c} !== '0) begin
      errors++; $display("FAIL abort_async: got %h want 0", {busy, done, err, mmu_rst, mmu_valid_in, mmu_a, mmu_b, res_c});
    end
    tick();
    rst = 1'b0;
    model_reset();
    tick();
    checks++;
    if ({busy, done, res_c} !== '0) begin
      errors++; $display("FAIL abort_idle: got %h want 0", {busy, done, res_c});
    end
    load_random();
    run_job(2, 0, 0);
  endtask

  task automatic test_watchdog();
    load_random();
`ifdef MMU_SEQ_TIMEOUT_EN
    run_job(0, 1, 0);
    run_job(1, 0, 0);
`else
    vo_kill = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 1; n <= TO + 13; n++) begin
      checks++;
      if (busy !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
        errors++; $display("FAIL wd_stall n=%0d: got busy/done/err %b%b%b want 100", n, busy, done, err);
      end
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vo_kill = 1'b0;
    model_reset();
    tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL wd_abort: got %b want 0", busy); end
`endif
  endtask

  initial begin
    start = 1'b0; ld_en = 1'b0; ld_sel = 1'b0; ld_row = 1'b0; ld_col = 1'b0; ld_data = '0;
    lat = 0; vo_kill = 1'b0;
    model_reset();
    test_reset();
    test_feed();
    test_lockout();
    test_back_to_back();
    test_random();
    test_abort();
    test_watchdog();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
